// File: rtl/rx_side_assembler.sv
// Receive-side block assembler: packs four consecutive 32-bit side words into one
// 128-bit block, first word most significant, with a one-block output buffer.
module rx_side_assembler #(
    parameter int WORD_W    = 32,
    parameter int NUM_SIDES = 4
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        word_valid,
    input  logic [WORD_W-1:0]           word_in,
    output logic                        word_ready,
    output logic [1:0]                  side_idx,
    output logic                        blk_valid,
    output logic [WORD_W*NUM_SIDES-1:0] blk_out,
    input  logic                        blk_ready
);

    localparam int BLK_W = WORD_W * NUM_SIDES;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t             state_q;
    logic [1:0]         sideIdx_q, sideIdx_d;
    logic [BLK_W-1:0]   asm_q, asm_d;
    logic [BLK_W-1:0]   blkOut_q;
    logic               lastSide;
    logic               accept;
    logic               complete;
    logic               drain;

    // Only the closing word of a block can stall, and only while the output
    // register is still full and not being drained this cycle.
    always_comb begin
        lastSide   = (sideIdx_q == 2'd3);
        word_ready = !(lastSide && (state_q == HOLD) && !blk_ready);
        accept     = word_valid && word_ready && !clear;
        complete   = accept && lastSide;
        drain      = (state_q == HOLD) && blk_ready;
    end

    always_comb begin
        asm_d     = asm_q;
        sideIdx_d = sideIdx_q;
        if (clear) begin
            asm_d     = '0;
            sideIdx_d = 2'd0;
        end else if (accept) begin
            sideIdx_d = sideIdx_q + 2'd1;
            case (sideIdx_q)
                2'd0:    asm_d[BLK_W-1          -: WORD_W] = word_in;
                2'd1:    asm_d[BLK_W-1-WORD_W   -: WORD_W] = word_in;
                2'd2:    asm_d[BLK_W-1-2*WORD_W -: WORD_W] = word_in;
                default: asm_d[WORD_W-1         -: WORD_W] = word_in;
            endcase
        end
    end

    // asm_d already carries the closing word, so a completing edge copies the
    // full block; a completion on a draining edge keeps the FSM in HOLD.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= FILL;
            sideIdx_q <= 2'd0;
            asm_q     <= '0;
            blkOut_q  <= '0;
        end else begin
            asm_q     <= asm_d;
            sideIdx_q <= sideIdx_d;
            if (complete) begin
                state_q  <= HOLD;
                blkOut_q <= asm_d;
            end else if (drain) begin
                state_q  <= FILL;
            end
        end
    end

    assign side_idx  = sideIdx_q;
    assign blk_valid = (state_q == HOLD);
    assign blk_out   = blkOut_q;

endmodule

// File: tb/tb_rx_side_assembler.sv
// Directed self-checking bench for rx_side_assembler: fill, back-pressure,
// streaming, clear and mid-operation reset scenarios.
module tb_rx_side_assembler;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         word_valid;
    logic [31:0]  word_in;
    logic         word_ready;
    logic [1:0]   side_idx;
    logic         blk_valid;
    logic [127:0] blk_out;
    logic         blk_ready;

    int total;
    int bad;

    rx_side_assembler #(.WORD_W(32), .NUM_SIDES(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .word_valid (word_valid),
        .word_in    (word_in),
        .word_ready (word_ready),
        .side_idx   (side_idx),
        .blk_valid  (blk_valid),
        .blk_out    (blk_out),
        .blk_ready  (blk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word that must be accepted at the expected side index.
    task automatic applyStimulus(input string tag, input logic [31:0] w, input logic [1:0] expIdx);
        word_valid = 1'b1;
        word_in    = w;
        #1;
        checkOutput({tag, "_idx"},   128'(side_idx),   128'(expIdx));
        checkOutput({tag, "_ready"}, 128'(word_ready), 128'(1'b1));
        tick();
        word_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] expBlk;
        total      = 0;
        bad        = 0;
        n_rst      = 1'b1;
        clear      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        blk_ready  = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;

        checkOutput("rst_idx",   128'(side_idx),   128'(0));
        checkOutput("rst_valid", 128'(blk_valid),  128'(0));
        checkOutput("rst_out",   blk_out,          128'(0));
        checkOutput("rst_ready", 128'(word_ready), 128'(1));

        // Basic fill, downstream always ready
        blk_ready = 1'b1;
        applyStimulus("t1w0", 32'h11111111, 2'd0);
        applyStimulus("t1w1", 32'h22222222, 2'd1);
        applyStimulus("t1w2", 32'h33333333, 2'd2);
        checkOutput("t1_novalid", 128'(blk_valid), 128'(0));
        applyStimulus("t1w3", 32'h44444444, 2'd3);
        checkOutput("t1_valid", 128'(blk_valid), 128'(1));
        checkOutput("t1_out",   blk_out, 128'h11111111_22222222_33333333_44444444);
        checkOutput("t1_idx",   128'(side_idx), 128'(0));
        tick();
        checkOutput("t1_drained", 128'(blk_valid), 128'(0));

        // Back-pressure: first block held while the next three sides fill
        blk_ready = 1'b0;
        applyStimulus("t2a0", 32'hA0000001, 2'd0);
        applyStimulus("t2a1", 32'hA0000002, 2'd1);
        applyStimulus("t2a2", 32'hA0000003, 2'd2);
        applyStimulus("t2a3", 32'hA0000004, 2'd3);
        checkOutput("t2_valid", 128'(blk_valid), 128'(1));
        applyStimulus("t2b0", 32'hB0000001, 2'd0);
        applyStimulus("t2b1", 32'hB0000002, 2'd1);
        applyStimulus("t2b2", 32'hB0000003, 2'd2);
        checkOutput("t2_hold_out", blk_out, 128'hA0000001_A0000002_A0000003_A0000004);
        word_valid = 1'b1;
        word_in    = 32'hB0000004;
        #1;
        checkOutput("t2_stall_ready", 128'(word_ready), 128'(0));
        tick();
        checkOutput("t2_stall_idx",   128'(side_idx),  128'(3));
        checkOutput("t2_stall_valid", 128'(blk_valid), 128'(1));
        checkOutput("t2_stall_out",   blk_out, 128'hA0000001_A0000002_A0000003_A0000004);
        blk_ready = 1'b1;
        #1;
        checkOutput("t2_release_ready", 128'(word_ready), 128'(1));
        tick();
        word_valid = 1'b0;
        checkOutput("t2_b_valid", 128'(blk_valid), 128'(1));
        checkOutput("t2_b_out",   blk_out, 128'hB0000001_B0000002_B0000003_B0000004);
        checkOutput("t2_b_idx",   128'(side_idx), 128'(0));
        tick();
        checkOutput("t2_drained", 128'(blk_valid), 128'(0));

        // Continuous stream of 12 words, downstream always ready
        for (int i = 0; i < 12; i++) begin
            applyStimulus("t3w", 32'hC0000000 + 32'(i), 2'(i % 4));
            if (i % 4 == 3) begin
                expBlk = {32'hC0000000 + 32'(i - 3), 32'hC0000000 + 32'(i - 2),
                          32'hC0000000 + 32'(i - 1), 32'hC0000000 + 32'(i)};
                checkOutput("t3_valid", 128'(blk_valid), 128'(1));
                checkOutput("t3_out",   blk_out, expBlk);
            end else begin
                checkOutput("t3_novalid", 128'(blk_valid), 128'(0));
            end
        end
        tick();
        checkOutput("t3_drained", 128'(blk_valid), 128'(0));

        // Clear discards a partial block; the offered word is ignored
        applyStimulus("t4a", 32'h0000000A, 2'd0);
        applyStimulus("t4b", 32'h0000000B, 2'd1);
        clear      = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'hDEADBEEF;
        tick();
        clear      = 1'b0;
        word_valid = 1'b0;
        checkOutput("t4_clear_idx", 128'(side_idx), 128'(0));
        applyStimulus("t4w0", 32'h00000001, 2'd0);
        applyStimulus("t4w1", 32'h00000002, 2'd1);
        applyStimulus("t4w2", 32'h00000003, 2'd2);
        applyStimulus("t4w3", 32'h00000004, 2'd3);
        checkOutput("t4_valid", 128'(blk_valid), 128'(1));
        checkOutput("t4_out",   blk_out, 128'h00000001_00000002_00000003_00000004);
        tick();

        // Clear with the closing word while a block is pending and stalled
        blk_ready = 1'b0;
        applyStimulus("t5d0", 32'hD0000001, 2'd0);
        applyStimulus("t5d1", 32'hD0000002, 2'd1);
        applyStimulus("t5d2", 32'hD0000003, 2'd2);
        applyStimulus("t5d3", 32'hD0000004, 2'd3);
        applyStimulus("t5e0", 32'hE0000001, 2'd0);
        applyStimulus("t5e1", 32'hE0000002, 2'd1);
        applyStimulus("t5e2", 32'hE0000003, 2'd2);
        clear      = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'hE0000004;
        tick();
        clear      = 1'b0;
        word_valid = 1'b0;
        checkOutput("t5_idx",   128'(side_idx),  128'(0));
        checkOutput("t5_valid", 128'(blk_valid), 128'(1));
        checkOutput("t5_out",   blk_out, 128'hD0000001_D0000002_D0000003_D0000004);

        // Clear beats an otherwise-accepted closing word on a draining edge
        applyStimulus("t5f0", 32'hF0000001, 2'd0);
        applyStimulus("t5f1", 32'hF0000002, 2'd1);
        applyStimulus("t5f2", 32'hF0000003, 2'd2);
        blk_ready  = 1'b1;
        clear      = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'hF0000004;
        tick();
        clear      = 1'b0;
        word_valid = 1'b0;
        checkOutput("t5_clearwin_valid", 128'(blk_valid), 128'(0));
        checkOutput("t5_clearwin_idx",   128'(side_idx),  128'(0));

        // Reset mid-operation with a pending block and a partial block
        blk_ready = 1'b0;
        applyStimulus("t6g0", 32'h12340001, 2'd0);
        applyStimulus("t6g1", 32'h12340002, 2'd1);
        applyStimulus("t6g2", 32'h12340003, 2'd2);
        applyStimulus("t6g3", 32'h12340004, 2'd3);
        applyStimulus("t6h0", 32'h56780001, 2'd0);
        applyStimulus("t6h1", 32'h56780002, 2'd1);
        checkOutput("t6_pre_idx",   128'(side_idx),  128'(2));
        checkOutput("t6_pre_valid", 128'(blk_valid), 128'(1));
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        checkOutput("t6_idx",   128'(side_idx),   128'(0));
        checkOutput("t6_valid", 128'(blk_valid),  128'(0));
        checkOutput("t6_out",   blk_out,          128'(0));
        checkOutput("t6_ready", 128'(word_ready), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
